mult_pipe_hs_wrapper: RTL
=========================

// Module: mult_pipe_hs_wrapper
// PURPOSE
//  Parametrised, elastic pipelined multiplier with valid/ready handshakes on both sides.
//  Per-transaction signed/unsigned mode and a sideband tag travel with each operand pair.
//  Supports backpressure with bubble collapsing and reports the number of transactions in flight.
//  Drop-in timing harness for generated multiplier cores in synthesis runs; the product is
//  formed internally with a sized multiply in stage 1.
// PARAMETERS
//  WIDTH        16  operand width in bits; product is 2*WIDTH bits; legal range 2..64
//  PIPE_STAGES  3   register stages from accept to out_valid; legal range 2..8
//  TAG_W        4   sideband tag width in bits; legal range 1..16
// PORTS
//  clk           in   1            rising-edge clock; the only clock
//  rst           in   1            synchronous reset, active-high
//  in_valid      in   1            operand pair present
//  in_ready      out  1            block accepts this cycle
//  in_signed     in   1            1: two's-complement operands; 0: unsigned
//  multiplicand  in   WIDTH        operand A
//  multiplier    in   WIDTH        operand B
//  in_tag        in   TAG_W        sideband, returned unchanged with the result
//  out_valid     out  1            product present
//  out_ready     in   1            consumer takes product this cycle
//  product       out  2*WIDTH      A*B, interpreted according to in_signed
//  out_tag       out  TAG_W        tag of this product
//  in_flight     out  clog2(PIPE_STAGES+1)  number of occupied stages
// BEHAVIOUR
//  - Reset: all stage valid bits clear. Result: out_valid=0, in_ready=1, in_flight=0,
//    product=0, out_tag=0. Data registers are also cleared to 0.
//  - Reset mid-operation: every in-flight transaction is discarded; no output occurs after reset.
//  - Stages S1..SN with N=PIPE_STAGES; each stage holds {valid, signed, A/B or partial, tag}.
//  - Accept: a transfer occurs when in_valid && in_ready at a clock edge; the pair is loaded into S1.
//  - Deliver: a transfer occurs when out_valid && out_ready. out_valid = SN.valid, and the
//    outputs are driven from SN registers only (no combinational path from inputs to outputs).
//  - Stage advance rule: Sk loads from S(k-1) when !Sk.valid, or when Sk advances this cycle.
//    SN advances when out_ready. Empty stages are filled, so bubbles collapse.
//  - in_ready = !S1.valid || S1 advances this cycle. This is a combinational path from
//    out_ready through the chain of valid bits; it is accepted for N<=8.
//  - Latency, uncontended: a product is accepted at edge t and has out_valid=1 after
//    edge t+N-1, i.e. N-1 cycles after acceptance.
//  - Throughput: 1 transfer per cycle when out_ready is held high.
//  - Full pipeline (all N stages valid) with out_ready=0: in_ready=0 and all stages hold.
//    Output data stays stable while out_valid=1 and out_ready=0.
//  - Arithmetic:
//    - signed: operands are sign-extended to WIDTH+1 bits; the product is the low 2*WIDTH
//      bits of the (2*WIDTH+2)-bit result. This equals the exact signed product, including
//      (-2^(W-1))^2.
//    - unsigned: operands are zero-extended in the same way.
//    - Stage placement: the full product is computed in S1->S2; the remaining stages are
//      retiming registers.
//  - in_flight: count of valid stages. Increment on accept, decrement on deliver, unchanged
//    when both occur in the same cycle. It never exceeds N.
//  - Simultaneous accept and deliver when the pipeline is full: allowed (in_ready=1 via the
//    advance rule); occupancy stays at N.
//  - in_signed and in_tag are sampled only on accept. Changes to the inputs while in_ready=0
//    have no effect.
// TESTING
//  1. Reset, then hold out_ready=1 and inject A=16'hFFFF, B=16'hFFFF, unsigned, tag 3.
//     Expect product=32'hFFFE0001, out_tag=3, out_valid exactly 2 cycles after accept.
//  2. Signed mode: A=16'h8000, B=16'h8000 -> 32'h40000000. A=16'hFFFF (-1), B=16'h0005
//     -> 32'hFFFFFFFB. Expect the same bit pattern in unsigned mode to give 32'h0004FFFB.
//  3. Backpressure: out_ready=0, stream 5 pairs 1*1..5*5. Expect in_ready to drop after
//     the 3rd accept, in_flight=3, and the held product stable at 1. Then raise out_ready:
//     expect 1,4,9,16,25 in order with no loss or duplication.
//  4. Bubble collapse: accept one pair, idle 1 cycle, accept a second, out_ready=0.
//     Expect both to end in S3/S2 with in_flight=2 and in_ready=1.
//  5. Full-pipe pass-through: with the pipeline full and out_ready=1 and in_valid=1
//     every cycle, expect in_ready=1, in_flight constant at 3, and 1 product per cycle.
//  6. Reset with 3 products in flight: the cycle after rst, out_valid=0 and in_flight=0,
//     and no stale product appears afterwards. Also randomised checks at WIDTH=8 and
//     PIPE_STAGES=2, compared against a reference model.

Source files
------------

// File: rtl/mult_pipe_hs_wrapper.sv
// Elastic pipelined multiplier with valid/ready on both sides.
// Signed/unsigned mode and a tag travel with each operand pair.
module mult_pipe_hs_wrapper #(
    parameter int WIDTH       = 16,
    parameter int PIPE_STAGES = 3,
    parameter int TAG_W       = 4,
    localparam int CW         = $clog2(PIPE_STAGES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [TAG_W-1:0]     out_tag,
    output logic [CW-1:0]        in_flight
);

    typedef struct packed {
        logic             sgn;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
    } op_t;

    typedef struct packed {
        logic [2*WIDTH-1:0] prod;
        logic [TAG_W-1:0]   tag;
    } res_t;

    localparam int N = PIPE_STAGES;

    op_t                s1_q;
    res_t               res_q [1:N-1];
    logic [N-1:0]       vld_q;
    logic [N-1:0]       ld;
    logic [2*WIDTH-1:0] ea;
    logic [2*WIDTH-1:0] eb;
    logic [2*WIDTH-1:0] mul_lo;
    logic [CW-1:0]      cnt_q;
    logic               acc;
    logic               dlv;

    // Load enables ripple back from the output so empty stages refill
    always_comb begin
        ld = '0;
        ld[N-1] = !vld_q[N-1] || out_ready;
        for (int k = N - 2; k >= 0; k--) begin
            ld[k] = !vld_q[k] || ld[k+1];
        end
    end

    // Extension to 2W bits leaves the low 2W product bits identical
    // to the (W+1)-bit signed/zero-extended multiply
    always_comb begin
        ea     = {{WIDTH{s1_q.sgn & s1_q.a[WIDTH-1]}}, s1_q.a};
        eb     = {{WIDTH{s1_q.sgn & s1_q.b[WIDTH-1]}}, s1_q.b};
        mul_lo = ea * eb;
    end

    // Stage registers: S1 holds operands, S2..SN hold product and tag
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            s1_q  <= '0;
            for (int k = 1; k < N; k++) begin
                res_q[k] <= '0;
            end
        end else begin
            if (ld[0]) begin
                vld_q[0] <= in_valid;
                if (in_valid) begin
                    s1_q <= {in_signed, multiplicand, multiplier, in_tag};
                end
            end
            if (ld[1]) begin
                vld_q[1] <= vld_q[0];
                if (vld_q[0]) begin
                    res_q[1] <= {mul_lo, s1_q.tag};
                end
            end
            for (int k = 2; k < N; k++) begin
                if (ld[k]) begin
                    vld_q[k] <= vld_q[k-1];
                    if (vld_q[k-1]) begin
                        res_q[k] <= res_q[k-1];
                    end
                end
            end
        end
    end

    assign acc = in_valid && ld[0];
    assign dlv = vld_q[N-1] && out_ready;

    // Occupancy counter: +1 on accept, -1 on deliver
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (acc && !dlv) begin
            cnt_q <= cnt_q + CW'(1);
        end else if (!acc && dlv) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = vld_q[N-1];
    assign product   = res_q[N-1].prod;
    assign out_tag   = res_q[N-1].tag;
    assign in_flight = cnt_q;

endmodule
